// File: rtl/demux1x5_skid.sv
`default_nettype none
// ============================================================================
//  Module      : demux1x5_skid
//  Description : Registered 1-to-5 demultiplexer with a valid/ready handshake.
//                A single producer beat is steered to one of five consumers
//                chosen by {sel2,sel1,sel0}. A head register drives the
//                outputs. A one-beat skid register lets in_ready be a flop
//                while sustaining one beat per clock.
//  Revision    : 1.0 - initial release
// ============================================================================
module demux1x5_skid #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [XLEN-1:0] in_data,
    input  logic            sel0,
    input  logic            sel1,
    input  logic            sel2,
    output logic [4:0]      out_valid,
    input  logic [4:0]      out_ready,
    output logic [XLEN-1:0] out_data
);

    // Occupancy of the head/skid pair.
    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_TWO   = 2'd2
    } state_t;

    state_t            state_q,     state_d;
    logic              in_ready_q,  in_ready_d;
    logic [XLEN-1:0]   head_data_q, head_data_d;
    logic [4:0]        head_vld_q,  head_vld_d;
    logic [XLEN-1:0]   skid_data_q, skid_data_d;
    logic [4:0]        skid_dest_q, skid_dest_d;

    logic [2:0]        w_sel;
    logic [4:0]        w_in_dest;
    logic              w_accept;
    logic              w_fire;

    // Destination codes 101/110/111 fall back to port 0, matching the
    // default leg of the companion result-select mux.
    function automatic logic [4:0] decode_dest(input logic [2:0] code);
        logic [4:0] oh;
        case (code)
            3'd0:    oh = 5'b00001;
            3'd1:    oh = 5'b00010;
            3'd2:    oh = 5'b00100;
            3'd3:    oh = 5'b01000;
            3'd4:    oh = 5'b10000;
            default: oh = 5'b00001;
        endcase
        return oh;
    endfunction

    assign w_sel     = {sel2, sel1, sel0};
    assign w_in_dest = decode_dest(w_sel);

    // Handshake events. Only the head's own port can complete a fire; the
    // ready bits of the other ports are masked off by the one-hot valid.
    assign w_accept = in_valid & in_ready_q;
    assign w_fire   = |(head_vld_q & out_ready);

    // Next-state and datapath steering for head and skid registers.
    always_comb begin
        state_d     = state_q;
        head_data_d = head_data_q;
        head_vld_d  = head_vld_q;
        skid_data_d = skid_data_q;
        skid_dest_d = skid_dest_q;

        case (state_q)
            ST_EMPTY: begin
                if (w_accept) begin
                    head_data_d = in_data;
                    head_vld_d  = w_in_dest;
                    state_d     = ST_ONE;
                end
            end
            ST_ONE: begin
                if (w_accept && w_fire) begin
                    // Head leaves and is replaced in the same cycle: no bubble.
                    head_data_d = in_data;
                    head_vld_d  = w_in_dest;
                end else if (w_accept) begin
                    // Head is stalled; park the new beat behind it.
                    skid_data_d = in_data;
                    skid_dest_d = w_in_dest;
                    state_d     = ST_TWO;
                end else if (w_fire) begin
                    // out_data keeps its last value; only valid drops.
                    head_vld_d  = 5'b00000;
                    state_d     = ST_EMPTY;
                end
            end
            ST_TWO: begin
                // in_ready is low here, so only a fire can move things along.
                if (w_fire) begin
                    head_data_d = skid_data_q;
                    head_vld_d  = skid_dest_q;
                    state_d     = ST_ONE;
                end
            end
            default: begin
                head_vld_d = 5'b00000;
                state_d    = ST_EMPTY;
            end
        endcase
    end

    // in_ready is derived from the next occupancy so that it can be a flop
    // and still never admit a third beat.
    always_comb begin
        in_ready_d = (state_d != ST_TWO);
    end

    // State, head, skid and in_ready registers; reset drops any held beats.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_EMPTY;
            in_ready_q  <= 1'b1;
            head_data_q <= '0;
            head_vld_q  <= 5'b00000;
            skid_data_q <= '0;
            skid_dest_q <= 5'b00000;
        end else begin
            state_q     <= state_d;
            in_ready_q  <= in_ready_d;
            head_data_q <= head_data_d;
            head_vld_q  <= head_vld_d;
            skid_data_q <= skid_data_d;
            skid_dest_q <= skid_dest_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = head_vld_q;
    assign out_data  = head_data_q;

endmodule
`default_nettype wire

// File: tb/tb_demux1x5_skid.sv
`default_nettype none
// ============================================================================
//  Module      : tb_demux1x5_skid
//  Description : Self-checking bench for demux1x5_skid. A queue-based model
//                of the held beats predicts in_ready, out_valid and out_data;
//                directed sequences add literal expectations.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_demux1x5_skid;

    localparam int XLEN = 32;

    logic            clk = 1'b0;
    logic            rst;
    logic            in_valid;
    logic            in_ready;
    logic [XLEN-1:0] in_data;
    logic            sel0, sel1, sel2;
    logic [4:0]      out_valid;
    logic [4:0]      out_ready;
    logic [XLEN-1:0] out_data;

    demux1x5_skid #(.XLEN(XLEN)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .sel0      (sel0),
        .sel1      (sel1),
        .sel2      (sel2),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_fail = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model: FIFO of at most two beats ----------
    typedef struct {
        logic [XLEN-1:0] d;
        int              p;
    } beat_t;

    beat_t q[$];
    bit    model_en   = 1'b0;
    bit    bubble_win = 1'b0;
    int    bubbles    = 0;
    int    fired      = 0;

    function automatic int dest_of(input logic [2:0] s);
        return (s > 3'd4) ? 0 : int'(s);
    endfunction

    always @(posedge clk) begin
        if (rst) begin
            q.delete();
            model_en = 1'b1;
        end else if (model_en) begin
            bit f, a;
            f = (q.size() > 0) && out_ready[q[0].p];
            a = in_valid && (q.size() < 2);
            if (f) begin
                void'(q.pop_front());
                fired++;
            end
            if (a) q.push_back('{d: in_data, p: dest_of({sel2, sel1, sel0})});
        end
    end

    // Compare process: DUT outputs against the model every cycle.
    always @(negedge clk) begin
        if (model_en) begin
            logic [4:0] ev;
            ev = (q.size() > 0) ? (5'b00001 << q[0].p) : 5'b00000;
            chk("in_ready", in_ready, (q.size() < 2));
            chk("out_valid", out_valid, ev);
            if (q.size() > 0) chk("out_data", out_data, q[0].d);
            if (bubble_win && out_valid == 5'b0) bubbles++;
        end
    end

    // ---------------- stimulus -----------------------------------------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input bit v, input logic [XLEN-1:0] d, input logic [2:0] s);
        in_valid = v;
        in_data  = d;
        {sel2, sel1, sel0} = s;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        drive(1'b0, '0, 3'd0);
        out_ready = 5'b0;
        tick();
        tick();
        // Reset values
        chk("rst_in_ready", in_ready, 1'b1);
        chk("rst_out_valid", out_valid, 5'b0);
        chk("rst_out_data", out_data, 32'h0);
        rst = 1'b0;

        // Routing of legal codes, one beat per clock
        out_ready = 5'h1F;
        for (int i = 0; i < 5; i++) begin
            drive(1'b1, 32'hA0 + i, 3'(i));
            tick();
            chk("route_valid", out_valid, 5'b00001 << i);
            chk("route_data", out_data, 32'hA0 + i);
        end
        // Illegal codes default to port 0
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 32'hBAD0 + i, 3'(5 + i));
            tick();
            chk("illegal_valid", out_valid, 5'b00001);
            chk("illegal_data", out_data, 32'hBAD0 + i);
        end
        drive(1'b0, '0, 3'd0);
        tick();
        chk("drain_valid", out_valid, 5'b0);

        // Backpressure fills head and skid
        out_ready = 5'b0;
        drive(1'b1, 32'h11, 3'd2);
        tick();
        chk("bp_valid1", out_valid, 5'b00100);
        chk("bp_ready1", in_ready, 1'b1);
        drive(1'b1, 32'h22, 3'd3);
        tick();
        chk("bp_ready2", in_ready, 1'b0);
        drive(1'b1, 32'h33, 3'd1);
        tick();
        tick();
        chk("bp_held_ready", in_ready, 1'b0);
        chk("bp_held_data", out_data, 32'h11);
        chk("bp_held_valid", out_valid, 5'b00100);
        drive(1'b0, '0, 3'd0);
        out_ready = 5'h1F;
        tick();
        chk("bp_rel_valid", out_valid, 5'b01000);
        chk("bp_rel_data", out_data, 32'h22);
        chk("bp_rel_ready", in_ready, 1'b1);
        tick();
        chk("bp_empty", out_valid, 5'b0);

        // Reset while holding two beats
        out_ready = 5'b0;
        drive(1'b1, 32'h5555, 3'd4);
        tick();
        drive(1'b1, 32'h6666, 3'd1);
        tick();
        chk("two_ready", in_ready, 1'b0);
        drive(1'b0, '0, 3'd0);
        rst = 1'b1;
        tick();
        chk("mid_rst_valid", out_valid, 5'b0);
        chk("mid_rst_ready", in_ready, 1'b1);
        chk("mid_rst_data", out_data, 32'h0);
        rst = 1'b0;
        out_ready = 5'h1F;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("post_rst_quiet", out_valid, 5'b0);
        end

        // Random traffic with random consumer readiness
        for (int i = 0; i < 400; i++) begin
            drive(1'($urandom_range(0, 3) != 0), $urandom, 3'($urandom_range(0, 7)));
            out_ready = 5'($urandom);
            tick();
        end
        drive(1'b0, '0, 3'd0);
        out_ready = 5'h1F;
        tick();
        tick();

        // Full-rate streaming: every cycle must carry a beat
        fired = 0;
        drive(1'b1, $urandom, 3'($urandom_range(0, 7)));
        tick();
        bubble_win = 1'b1;
        for (int i = 0; i < 60; i++) begin
            drive(1'b1, $urandom, 3'($urandom_range(0, 7)));
            tick();
        end
        bubble_win = 1'b0;
        drive(1'b0, '0, 3'd0);
        chk("stream_bubbles", bubbles, 0);
        chk("stream_fired", fired, 60);
        tick();
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
